// File: rtl/alu_pkg.sv
// Shared definitions for the FakeCPU integer ALU: default width and operation codes.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SUBU = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SLL  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1110;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the instruction decoder (master) and the ALU (slave).
interface alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] rd;
  logic             overflow;

  modport master (output rs, output rt, output ctrl, input rd, input overflow);
  modport slave  (input rs, input rt, input ctrl, output rd, output overflow);

endinterface

// File: rtl/alu_comb.sv
// Purely combinational ALU function: result and signed-overflow flag from ctrl/rs/rt.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [3:0]       ctrl,
  output logic [WIDTH-1:0] rd,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic             add_ov;
  logic             sub_ov;

  assign sum   = rs + rt;
  assign diff  = rs - rt;
  // Only the low bits of rt select the shift; the upper bits are don't-care.
  assign shamt = rt[SHW-1:0];

  assign add_ov = (rs[WIDTH-1] == rt[WIDTH-1]) && (sum[WIDTH-1]  != rs[WIDTH-1]);
  assign sub_ov = (rs[WIDTH-1] != rt[WIDTH-1]) && (diff[WIDTH-1] != rs[WIDTH-1]);

  always_comb begin
    rd       = '0;
    overflow = 1'b0;
    case (ctrl)
      ALU_ADDU: rd = sum;
      ALU_ADD: begin
        rd       = sum;
        overflow = add_ov;
      end
      ALU_SUBU: rd = diff;
      ALU_SUB: begin
        rd       = diff;
        overflow = sub_ov;
      end
      ALU_AND:  rd = rs & rt;
      ALU_OR:   rd = rs | rt;
      ALU_XOR:  rd = rs ^ rt;
      ALU_NOR:  rd = ~(rs | rt);
      ALU_SLTU: rd = {{(WIDTH-1){1'b0}}, (rs < rt)};
      ALU_SLT:  rd = {{(WIDTH-1){1'b0}}, ($signed(rs) < $signed(rt))};
      ALU_SLL:  rd = rs << shamt;
      ALU_SRL:  rd = rs >> shamt;
      ALU_SRA:  rd = $unsigned($signed(rs) >>> shamt);
      default: begin
        rd       = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered ALU: one cycle from operands to rd/overflow, matching the decoder's calculate cycle.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic    clk,
  input  logic    rst_n,
  alu_if.slave    bus
);

  logic [WIDTH-1:0] rd_next;
  logic             overflow_next;
  logic [WIDTH-1:0] rd_reg;
  logic             overflow_reg;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .rs       (bus.rs),
    .rt       (bus.rt),
    .ctrl     (bus.ctrl),
    .rd       (rd_next),
    .overflow (overflow_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_reg       <= '0;
      overflow_reg <= 1'b0;
    end else begin
      rd_reg       <= rd_next;
      overflow_reg <= overflow_next;
    end
  end

  assign bus.rd       = rd_reg;
  assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver queues hand-computed expectations, monitor checks each cycle.
module tb_alu;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] rd;
    logic        ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  always #5 clk = ~clk;

  alu_if #(.WIDTH(32)) bus ();

  alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic apply(input logic r, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e_rd, input logic e_ov,
                       input string nm);
    exp_t e;
    @(negedge clk);
    rst_n    = r;
    bus.ctrl = c;
    bus.rs   = a;
    bus.rt   = b;
    e.rd     = e_rd;
    e.ov     = e_ov;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: every edge registers the previous cycle's inputs, so pop one entry per edge.
  always @(posedge clk) begin
    exp_t  e;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if (bus.rd !== e.rd || bus.overflow !== e.ov) begin
        n_miss++;
        $display("FAIL %s: got rd=%h ov=%b, expected rd=%h ov=%b",
                 nm, bus.rd, bus.overflow, e.rd, e.ov);
      end else begin
        $display("ok   %s: rd=%h ov=%b", nm, bus.rd, bus.overflow);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    bus.ctrl = ALU_ADD;
    bus.rs   = 32'd5;
    bus.rt   = 32'd7;

    apply(1'b0, ALU_ADD,  32'd5,        32'd7,        32'h0000_0000, 1'b0, "reset_hold");
    apply(1'b0, ALU_ADD,  32'd5,        32'd7,        32'h0000_0000, 1'b0, "reset_hold2");
    apply(1'b1, ALU_ADD,  32'd5,        32'd7,        32'd12,        1'b0, "reset_release_add");

    apply(1'b1, ALU_ADD,  32'h7FFF_FFFF, 32'd1,       32'h8000_0000, 1'b1, "add_ov_pos");
    apply(1'b1, ALU_ADDU, 32'h7FFF_FFFF, 32'd1,       32'h8000_0000, 1'b0, "addu_no_ov");
    apply(1'b1, ALU_ADD,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, "add_ov_neg");
    apply(1'b1, ALU_ADD,  32'hFFFF_FFFF, 32'd1,       32'h0000_0000, 1'b0, "add_mixed_sign");

    apply(1'b1, ALU_SUB,  32'h8000_0000, 32'd1,       32'h7FFF_FFFF, 1'b1, "sub_ov_neg");
    apply(1'b1, ALU_SUBU, 32'd3,        32'd5,        32'hFFFF_FFFE, 1'b0, "subu_wrap");
    apply(1'b1, ALU_SUB,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "sub_ov_pos");
    apply(1'b1, ALU_SUB,  32'd5,        32'd3,        32'd2,         1'b0, "sub_plain");
    apply(1'b1, ALU_SUBU, 32'h8000_0000, 32'd1,       32'h7FFF_FFFF, 1'b0, "subu_no_ov");

    apply(1'b1, ALU_SLT,  32'hFFFF_FFFF, 32'd1,       32'd1,         1'b0, "slt_neg_lt");
    apply(1'b1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1,       32'd0,         1'b0, "sltu_big");
    apply(1'b1, ALU_SLT,  32'd9,        32'd9,        32'd0,         1'b0, "slt_equal");
    apply(1'b1, ALU_SLTU, 32'd9,        32'd9,        32'd0,         1'b0, "sltu_equal");
    apply(1'b1, ALU_SLT,  32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0, "slt_pos_vs_neg");
    apply(1'b1, ALU_SLTU, 32'd1,        32'hFFFF_FFFF, 32'd1,        1'b0, "sltu_small");

    apply(1'b1, ALU_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, "and");
    apply(1'b1, ALU_OR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, "or");
    apply(1'b1, ALU_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, "xor");
    apply(1'b1, ALU_NOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F, 1'b0, "nor");

    apply(1'b1, ALU_SRA,  32'h8000_0000, 32'd4,       32'hF800_0000, 1'b0, "sra_neg");
    apply(1'b1, ALU_SRL,  32'h8000_0000, 32'd4,       32'h0800_0000, 1'b0, "srl_neg");
    apply(1'b1, ALU_SLL,  32'd1,        32'd31,       32'h8000_0000, 1'b0, "sll_31");
    apply(1'b1, ALU_SRA,  32'h7000_0000, 32'd4,       32'h0700_0000, 1'b0, "sra_pos");
    apply(1'b1, ALU_SLL,  32'h1234_5678, 32'd0,       32'h1234_5678, 1'b0, "sll_zero");
    apply(1'b1, ALU_SRA,  32'h8765_4321, 32'd0,       32'h8765_4321, 1'b0, "sra_zero");
    apply(1'b1, ALU_SLL,  32'd1,        32'hFFFF_FFE3, 32'd8,        1'b0, "sll_hi_ignored");
    apply(1'b1, ALU_SRL,  32'h8000_0000, 32'hFFFF_FFE4, 32'h0800_0000, 1'b0, "srl_hi_ignored");

    apply(1'b1, 4'b0010,  32'hDEAD_BEEF, 32'h1234_5678, 32'd0,       1'b0, "reserved_0010");
    apply(1'b1, 4'b0011,  32'h7FFF_FFFF, 32'd1,       32'd0,         1'b0, "reserved_0011");
    apply(1'b1, 4'b1111,  32'hFFFF_FFFF, 32'd4,       32'd0,         1'b0, "reserved_1111");

    apply(1'b1, ALU_ADD,  32'h7FFF_FFFF, 32'd1,       32'h8000_0000, 1'b1, "b2b_add_ov");
    apply(1'b0, ALU_ADD,  32'h7FFF_FFFF, 32'd1,       32'd0,         1'b0, "reset_wins");
    apply(1'b1, ALU_OR,   32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, "after_reset_or");

    // Drain: the last expectation is checked on the next edge; bound the wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
